// File: rtl/shift_reg_univ.sv
// WIDTH-bit universal shift register with eight idle-time modes and a
// parallel-to-serial (LSB-first) serializer sequence with busy/done handshake.
module shift_reg_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      q_reg     <= RESET_VAL;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // done_next defaults low, so the pulse clears on the next edge even with en=0.
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    if (en) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            q_next     = d;
            cnt_next   = CNT_LAST;
            state_next = SHIFT;
          end else begin
            case (mode)
              3'b000: q_next = q_reg;
              3'b001: q_next = d;
              3'b010: q_next = {q_reg[WIDTH-2:0], sin_r};
              3'b011: q_next = {sin_l, q_reg[WIDTH-1:1]};
              3'b100: q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
              3'b101: q_next = {q_reg[0], q_reg[WIDTH-1:1]};
              3'b110: q_next = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
              3'b111: q_next = {WIDTH{1'b0}};
              default: q_next = q_reg;
            endcase
          end
        end
        SHIFT: begin
          q_next = {sin_l, q_reg[WIDTH-1:1]};
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign q      = q_reg;
  assign sout_l = q_reg[WIDTH-1];
  assign sout_r = q_reg[0];
  assign busy   = (state_reg == SHIFT);
  assign done   = done_reg;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ (WIDTH=8, RESET_VAL=8'hA5).
module tb_shift_reg_univ;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic mode_op(input logic [2:0] m, input logic sl, input logic sr,
                         input logic [7:0] exp, input string tag);
    mode = 3'b001; d = 8'h96; start = 1'b0; en = 1'b1;
    step();
    mode = m; sin_l = sl; sin_r = sr;
    step();
    chk(tag, q, exp);
    sin_l = 1'b0; sin_r = 1'b0; mode = 3'b000;
  endtask

  // LSB-first serial streams written out by hand
  logic [7:0] bits_b4 [8] = '{0, 0, 1, 0, 1, 1, 0, 1};
  logic [7:0] bits_5a [8] = '{0, 1, 0, 1, 1, 0, 1, 0};

  initial begin
    int ncyc;
    reset_n = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0;

    // reset state
    step();
    chk("rst_q", q, 8'hA5);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    #1 reset_n = 1'b1;

    // load and serial outputs
    en = 1'b1; mode = 3'b001; d = 8'h96;
    step();
    chk("load", q, 8'h96);
    chk("sout_l", {7'd0, sout_l}, 8'd1);
    chk("sout_r", {7'd0, sout_r}, 8'd0);

    // modes from 8'h96
    mode_op(3'b010, 1'b0, 1'b1, 8'h2D, "shl");
    mode_op(3'b011, 1'b0, 1'b0, 8'h4B, "shr");
    mode_op(3'b100, 1'b0, 1'b0, 8'h2D, "rol");
    mode_op(3'b101, 1'b0, 1'b0, 8'h4B, "ror");
    mode_op(3'b110, 1'b0, 1'b0, 8'hCB, "asr");
    mode_op(3'b111, 1'b0, 1'b0, 8'h00, "clear");
    mode_op(3'b000, 1'b1, 1'b1, 8'h96, "hold");

    // en=0 freezes idle modes
    en = 1'b0; mode = 3'b111;
    step();
    chk("en0_freeze", q, 8'h96);
    en = 1'b1; mode = 3'b000;

    // plain serializer run
    start = 1'b1; d = 8'hB4;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ser_busy%0d", k), {7'd0, busy}, 8'd1);
      chk($sformatf("ser_bit%0d", k), {7'd0, sout_r}, bits_b4[k]);
      chk($sformatf("ser_done%0d", k), {7'd0, done}, 8'd0);
      step();
    end
    chk("ser_done", {7'd0, done}, 8'd1);
    chk("ser_idle", {7'd0, busy}, 8'd0);
    step();
    chk("ser_done_clr", {7'd0, done}, 8'd0);
    chk("ser_q_end", q, 8'h00);

    // stall after bit 2
    start = 1'b1; d = 8'hB4;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("stl_bit%0d", k), {7'd0, sout_r}, bits_b4[k]);
      if (k == 2) begin
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          chk($sformatf("stl_hold%0d", s), {7'd0, sout_r}, 8'd1);
          chk($sformatf("stl_busy%0d", s), {7'd0, busy}, 8'd1);
          chk($sformatf("stl_done%0d", s), {7'd0, done}, 8'd0);
        end
        en = 1'b1;
      end
      step();
    end
    chk("stl_done", {7'd0, done}, 8'd1);
    en = 1'b0;
    step();
    chk("done_en0_clr", {7'd0, done}, 8'd0);
    chk("stl_idle", {7'd0, busy}, 8'd0);
    en = 1'b1;

    // start/mode ignored mid-run, restart on the done cycle
    start = 1'b1; d = 8'hB4;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ign_bit%0d", k), {7'd0, sout_r}, bits_b4[k]);
      if (k == 3) begin
        start = 1'b1; mode = 3'b001; d = 8'hFF;
      end else begin
        start = 1'b0; mode = 3'b000; d = 8'hB4;
      end
      step();
    end
    chk("ign_done", {7'd0, done}, 8'd1);
    start = 1'b1; d = 8'h5A;
    step();
    start = 1'b0;
    chk("rst_busy_next", {7'd0, busy}, 8'd1);
    chk("rst_q_load", q, 8'h5A);
    chk("rst_done_clr", {7'd0, done}, 8'd0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("re_bit%0d", k), {7'd0, sout_r}, bits_5a[k]);
      step();
    end
    chk("re_done", {7'd0, done}, 8'd1);
    step();

    // start beats mode=clear
    start = 1'b1; mode = 3'b111; d = 8'h3C;
    step();
    start = 1'b0; mode = 3'b000;
    chk("prio_q", q, 8'h3C);
    chk("prio_busy", {7'd0, busy}, 8'd1);
    step();
    step();
    chk("mid_q", q, 8'h0F);

    // asynchronous reset mid-sequence
    #1 reset_n = 1'b0;
    #1;
    chk("arst_q", q, 8'hA5);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_done", {7'd0, done}, 8'd0);
    #1 reset_n = 1'b1;
    step();
    chk("post_rst_q", q, 8'hA5);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);

    // counter restarts cleanly: busy lasts exactly 8 cycles
    start = 1'b1; d = 8'hB4;
    step();
    start = 1'b0;
    ncyc = 0;
    while (busy && ncyc < 20) begin
      ncyc++;
      step();
    end
    chk("busy_len", 8'(ncyc), 8'd8);
    chk("final_done", {7'd0, done}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with enable, eight operating modes and a built-in serializer (auto-shift) sequence.
- Serves as a general storage, shift and rotate element and as a parallel-to-serial converter for serial links in the lab datapaths.
- Sits between parallel producers (counters, ALU outputs) and bit-serial consumers.

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when low, all state is frozen.
- mode  input  3  operation select; applies only when idle.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input into the MSB.
- sin_r  input  1  serial input into the LSB.
- start  input  1  starts the serializer sequence.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q; this is the serial output.
- busy  output  1  high while the serializer sequence runs.
- done  output  1  one-cycle pulse when the serializer sequence completes.

Behaviour:
- Reset:
  - reset_n low asynchronously forces q=RESET_VAL, busy=0, done=0 and the internal bit counter cnt=0.
  - This applies at any time, including mid-sequence.
  - Release is synchronous to the next clk edge, which is the first functional edge.
- State is updated only on the rising edge of clk.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - done is a registered pulse. It is not a separate state.
- In IDLE with en=1 and start=1 (start has priority over mode):
  - q<=d, cnt<=WIDTH-1, go to SHIFT.
- In IDLE with en=1 and start=0, mode acts on the edge:
  - 000 hold: q<=q.
  - 001 load: q<=d.
  - 010 shl: q<={q[WIDTH-2:0], sin_r}.
  - 011 shr: q<={sin_l, q[WIDTH-1:1]}.
  - 100 rol: q<={q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ror: q<={q[0], q[WIDTH-1:1]}.
  - 110 asr: q<={q[WIDTH-1], q[WIDTH-1:1]}.
  - 111 clear: q<={WIDTH{1'b0}} (synchronous clear, independent of RESET_VAL).
- In SHIFT with en=1:
  - Each edge performs shr with sin_l into the MSB.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: go to IDLE and assert done=1 for the following cycle.
- Serializer timing:
  - busy is high for exactly WIDTH enabled cycles.
  - During the k-th busy cycle (k=0..WIDTH-1), sout_r=d[k]: LSB first, one bit per enabled cycle.
- mode and start are ignored while busy=1; a start during SHIFT is dropped, not queued.
- en=0 freezes q, cnt and the FSM state, so busy holds its value.
- done is always exactly one clk cycle wide, regardless of en. It is set by the completing edge and cleared on the next edge.
- done and a new start may coincide: a start on the cycle where done=1 is accepted, since the FSM is already IDLE.
- cnt width is $clog2(WIDTH). The counter never wraps, because decrement from 0 is not performed.

Test Plan:
- Reset: hold reset_n=0 mid-sequence (busy=1), RESET_VAL=8'hA5 -> q=8'hA5, busy=0, done=0 immediately, without waiting for a clock edge.
- Modes, WIDTH=8, starting from q=8'b1001_0110:
  - shl with sin_r=1 -> 8'h2D.
  - shr with sin_l=0 -> 8'h4B.
  - rol -> 8'h2D.
  - ror -> 8'h4B.
  - asr -> 8'hCB.
  - clear -> 8'h00.
  - hold -> unchanged.
- Serializer: start with d=8'hB4, en=1 held high -> sout_r sequence 0,0,1,0,1,1,0,1 over 8 cycles with busy=1; done=1 on cycle 9 only; then busy=0.
- Stall: during a serializer run, drop en for 3 cycles after bit 2 -> sout_r holds bit 2 for those cycles; busy stays 1; the total bit sequence is unchanged; done still pulses once.
- Ignored inputs: assert start and mode=001 with d=8'hFF mid-run -> no reload, and the serial stream continues. Assert start on the done cycle -> a new run begins, with busy high the next cycle.
- Priority: in IDLE, start=1 with mode=111 -> q<=d (not cleared), and busy rises.
